// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared core constants: opcodes, control codes, load/store formats, FSM states
package dmem_responder_pkg;

    // Major opcodes of the memory instructions
    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    // Memory access kind carried on the control path
    localparam logic [1:0] CTL_MEM_NONE  = 2'd0;
    localparam logic [1:0] CTL_MEM_READ  = 2'd1;
    localparam logic [1:0] CTL_MEM_WRITE = 2'd2;

    // funct3 data formats
    localparam logic [2:0] FMT_B  = 3'b000;
    localparam logic [2:0] FMT_H  = 3'b001;
    localparam logic [2:0] FMT_W  = 3'b010;
    localparam logic [2:0] FMT_BU = 3'b100;
    localparam logic [2:0] FMT_HU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_READ_WAIT
    } dmem_state_t;

    function automatic logic fmt_valid(input logic [2:0] fmt);
        return (fmt == FMT_B) || (fmt == FMT_H) || (fmt == FMT_W) ||
               (fmt == FMT_BU) || (fmt == FMT_HU);
    endfunction

    function automatic logic fmt_aligned(input logic [2:0] fmt, input logic [1:0] offset);
        case (fmt)
            FMT_H, FMT_HU: return ~offset[0];
            FMT_W:         return offset == 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

    // Byte lanes touched by an aligned access of the given format
    function automatic logic [3:0] fmt_lane_mask(input logic [2:0] fmt, input logic [1:0] offset);
        case (fmt)
            FMT_B, FMT_BU: return 4'b0001 << offset;
            FMT_H, FMT_HU: return 4'b0011 << offset;
            default:       return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_load_extender.sv
// rtl/dmem_responder_load_extender.sv - selects the loaded byte/half/word from an SRAM word and extends it
//
// Ports:
//   sram_rdata  in   raw 32-bit SRAM word
//   offset      in   byte offset of the access within the word
//   format      in   funct3 data format
//   read_data   out  sign- or zero-extended load result (0 for undefined formats)
module load_extender
    import dmem_responder_pkg::*;
(
    input  logic [31:0] sram_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  format,
    output logic [31:0] read_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = sram_rdata[{offset, 3'b000} +: 8];
        // Halfwords are aligned, so only offset[1] picks the half
        half_sel  = sram_rdata[{offset[1], 4'b0000} +: 16];
        read_data = 32'h0;
        case (format)
            FMT_B:   read_data = {{24{byte_sel[7]}}, byte_sel};
            FMT_BU:  read_data = {24'h0, byte_sel};
            FMT_H:   read_data = {{16{half_sel[15]}}, half_sel};
            FMT_HU:  read_data = {16'h0, half_sel};
            FMT_W:   read_data = sram_rdata;
            default: read_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder between core load/store port and a synchronous SRAM
//
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   read_enable/write_enable core load/store request
//   address, write_data     byte address and store data
//   data_format             funct3 (B, H, W, BU, HU)
//   read_data               extended load result, valid in the cycle after the stall
//   stall                   holds the core for the SRAM read cycle
//   access_fault            pulse on a rejected access
//   sram_*                  SRAM strobe, byte mask, word address, write data, read data
//   load_stall_count        saturating count of stall cycles
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 12
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       read_enable,
    input  logic                       write_enable,
    input  logic [31:0]                address,
    input  logic [31:0]                write_data,
    input  logic [2:0]                 data_format,
    output logic [31:0]                read_data,
    output logic                       stall,
    output logic                       access_fault,
    output logic                       sram_enable,
    output logic [3:0]                 sram_write_mask,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]                sram_wdata,
    input  logic [31:0]                sram_rdata,
    output logic [31:0]                load_stall_count
);

    dmem_state_t state_q, state_d;
    logic [1:0]  offset_q;
    logic [2:0]  format_q;
    logic [1:0]  access_kind;
    logic        request_bad;
    logic        stall_c, fault_c, enable_c, respond_c, latch_c;
    logic [3:0]  mask_c;
    logic [31:0] extended;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^address[31:SRAM_ADDR_WIDTH+2];

    // Classify the incoming request independent of FSM state
    always_comb begin
        access_kind = CTL_MEM_NONE;
        request_bad = 1'b0;
        if (read_enable && write_enable) begin
            request_bad = 1'b1;
        end else if (read_enable || write_enable) begin
            if (!fmt_valid(data_format) || !fmt_aligned(data_format, address[1:0]))
                request_bad = 1'b1;
            else
                access_kind = read_enable ? CTL_MEM_READ : CTL_MEM_WRITE;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_c   = 1'b0;
        fault_c   = 1'b0;
        enable_c  = 1'b0;
        respond_c = 1'b0;
        latch_c   = 1'b0;
        mask_c    = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                fault_c = request_bad;
                if (access_kind == CTL_MEM_READ) begin
                    enable_c = 1'b1;
                    stall_c  = 1'b1;
                    latch_c  = 1'b1;
                    state_d  = ST_READ_WAIT;
                end else if (access_kind == CTL_MEM_WRITE) begin
                    enable_c = 1'b1;
                    mask_c   = fmt_lane_mask(data_format, address[1:0]);
                end
            end
            ST_READ_WAIT: begin
                // The load still presented here is the one already issued
                respond_c = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            offset_q         <= 2'b00;
            format_q         <= 3'b000;
            load_stall_count <= 32'h0;
        end else begin
            state_q <= state_d;
            if (latch_c) begin
                offset_q <= address[1:0];
                format_q <= data_format;
            end
            if (stall_c && load_stall_count != 32'hFFFF_FFFF)
                load_stall_count <= load_stall_count + 32'd1;
        end
    end

    load_extender u_load_extender (
        .sram_rdata (sram_rdata),
        .offset     (offset_q),
        .format     (format_q),
        .read_data  (extended)
    );

    always_comb begin
        sram_wdata = write_data;
        case (data_format)
            FMT_B, FMT_BU: sram_wdata = {4{write_data[7:0]}};
            FMT_H, FMT_HU: sram_wdata = {2{write_data[15:0]}};
            default:       sram_wdata = write_data;
        endcase
    end

    // Reset forces the strobes and result low immediately, not just at the next edge
    assign stall           = reset_n & stall_c;
    assign access_fault    = reset_n & fault_c;
    assign sram_enable     = reset_n & enable_c;
    assign sram_write_mask = reset_n ? mask_c : 4'b0000;
    assign read_data       = (reset_n && respond_c) ? extended : 32'h0;
    assign sram_addr       = address[SRAM_ADDR_WIDTH+1:2];

endmodule
